// File: rtl/debugger_tx_pkg.sv
// debugger_pkg: shared definitions for the UART debug link (transmit FSM
// states, frame header, receiver command codes, frame length helper).
// Optional feature macro: DEBUGGER_TX_CSUM_EN (adds the trailing XOR checksum byte).
package debugger_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    // Command codes decoded by the receiver half of the link
    localparam logic [1:0] CMD_STEP    = 2'b01;
    localparam logic [1:0] CMD_RUN_ALL = 2'b10;
    localparam logic [1:0] CMD_RESET   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        LOAD,
        SEND,
`ifdef DEBUGGER_TX_CSUM_EN
        CSUM,
`endif
        DONE,
        WAIT_LOW
    } state_t;

    // Bytes in one frame: header, PC, cycle count, register words, optional checksum
    function automatic int unsigned frame_len(input int unsigned num_regs,
                                              input int unsigned data_w);
        int unsigned n;
        n = 1 + (2 + num_regs) * (data_w / 8);
`ifdef DEBUGGER_TX_CSUM_EN
        n = n + 1;
`endif
        return n;
    endfunction

endpackage

// File: rtl/debugger_tx_if.sv
// debugger_tx_if: byte write port into the UART transmit FIFO.
interface debugger_tx_if;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;

    modport master (input tx_full, output wr_uart, output w_data);
    modport slave  (output tx_full, input wr_uart, input w_data);
endinterface

// File: rtl/debugger_tx_byte_serializer.sv
// byte_serializer: loads a word and emits its bytes MSB-first; a single-byte
// load sends only the top byte. Advances one byte per cycle while ready.
module byte_serializer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_single,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic [7:0]        byte_out,
    output logic              valid,
    output logic              last
);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;

    // Shift register and remaining-byte counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_data;
            cnt   <= load_single ? CNT_W'(1) : CNT_W'(NBYTES);
        end else if (ready && valid) begin
            shreg <= shreg << 8;
            cnt   <= cnt - CNT_W'(1);
        end
    end

    assign byte_out = shreg[DATA_W-1 -: 8];
    assign valid    = (cnt != '0);
    assign last     = (cnt == CNT_W'(1));
endmodule

// File: rtl/debugger_tx.sv
// debugger_tx: frames a pipeline snapshot (header, PC, cycle count, register
// file) into bytes for the UART TX FIFO and pulses data_sent when done.
// Optional feature macro: DEBUGGER_TX_CSUM_EN appends an XOR checksum byte
// covering every byte after the header.
module debugger_tx
    import debugger_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32,
    parameter logic [7:0]  HEADER   = HEADER_BYTE
) (
    input  logic                        clk,
    input  logic                        global_reset_n,
    input  logic                        send_data,
    input  logic [DATA_W-1:0]           pc_in,
    input  logic [DATA_W-1:0]           cycle_count,
    output logic [$clog2(NUM_REGS)-1:0] dbg_reg_addr,
    input  logic [DATA_W-1:0]           dbg_reg_data,
    debugger_tx_if.master               fifo,
    output logic                        data_sent,
    output logic                        busy
);
    localparam int unsigned AW    = $clog2(NUM_REGS);
    localparam int unsigned IDX_W = $clog2(NUM_REGS + 3);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS + 2);

    state_t            state;
    logic [DATA_W-1:0] pc_snap;
    logic [DATA_W-1:0] cnt_snap;
    logic [DATA_W-1:0] load_word;
    logic [IDX_W-1:0]  word_idx;
    logic              ser_load;
    logic              ser_single;
    logic              ser_ready;
    logic              ser_valid;
    logic              ser_last;
    logic [7:0]        ser_byte;
`ifdef DEBUGGER_TX_CSUM_EN
    logic [7:0]        csum;
`endif

    // Word source for the next LOAD: 0=header, 1=PC, 2=count, 3..=registers
    always_comb begin
        load_word  = dbg_reg_data;
        ser_single = 1'b0;
        if (word_idx == '0) begin
            load_word  = DATA_W'(HEADER) << (DATA_W - 8);
            ser_single = 1'b1;
        end else if (word_idx == IDX_W'(1)) begin
            load_word = pc_snap;
        end else if (word_idx == IDX_W'(2)) begin
            load_word = cnt_snap;
        end
    end

    assign ser_load  = (state == LOAD);
    assign ser_ready = (state == SEND) && !fifo.tx_full;

    byte_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk        (clk),
        .rst_n      (global_reset_n),
        .load       (ser_load),
        .load_single(ser_single),
        .load_data  (load_word),
        .ready      (ser_ready),
        .byte_out   (ser_byte),
        .valid      (ser_valid),
        .last       (ser_last)
    );

    // FIFO write in the same cycle a slot is free; byte holds while full
    always_comb begin
        fifo.wr_uart = 1'b0;
        fifo.w_data  = 8'h00;
        if (state == SEND) begin
            fifo.wr_uart = !fifo.tx_full && ser_valid;
            fifo.w_data  = ser_byte;
        end
`ifdef DEBUGGER_TX_CSUM_EN
        else if (state == CSUM) begin
            fifo.wr_uart = !fifo.tx_full;
            fifo.w_data  = csum;
        end
`endif
    end

    // Frame sequencer with snapshot, word index and register address
    always_ff @(posedge clk) begin
        if (!global_reset_n) begin
            state        <= IDLE;
            pc_snap      <= '0;
            cnt_snap     <= '0;
            word_idx     <= '0;
            dbg_reg_addr <= '0;
            data_sent    <= 1'b0;
            busy         <= 1'b0;
`ifdef DEBUGGER_TX_CSUM_EN
            csum         <= '0;
`endif
        end else begin
            data_sent <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send_data) begin
                        state <= SNAP;
                        busy  <= 1'b1;
                    end
                end
                SNAP: begin
                    pc_snap      <= pc_in;
                    cnt_snap     <= cycle_count;
                    word_idx     <= '0;
                    dbg_reg_addr <= '0;
`ifdef DEBUGGER_TX_CSUM_EN
                    csum         <= '0;
`endif
                    state        <= LOAD;
                end
                LOAD: state <= SEND;
                SEND: begin
                    if (!fifo.tx_full) begin
`ifdef DEBUGGER_TX_CSUM_EN
                        if (word_idx != '0) csum <= csum ^ ser_byte;
`endif
                        if (ser_last) begin
                            if (word_idx >= IDX_W'(3) && dbg_reg_addr != AW'(NUM_REGS - 1))
                                dbg_reg_addr <= dbg_reg_addr + AW'(1);
                            if (word_idx == LAST_IDX) begin
`ifdef DEBUGGER_TX_CSUM_EN
                                state     <= CSUM;
`else
                                state     <= DONE;
                                data_sent <= 1'b1;
`endif
                            end else begin
                                word_idx <= word_idx + IDX_W'(1);
                                state    <= LOAD;
                            end
                        end
                    end
                end
`ifdef DEBUGGER_TX_CSUM_EN
                CSUM: begin
                    if (!fifo.tx_full) begin
                        state     <= DONE;
                        data_sent <= 1'b1;
                    end
                end
`endif
                DONE: state <= WAIT_LOW;
                WAIT_LOW: begin
                    if (!send_data) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
